// File: rtl/mem_pkg.sv
// Shared data-memory definitions: geometry, response-select encoding and the
// address-error status code shared with the status logic.
package mem_pkg;
  localparam int N     = 64;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_I    = 2'd1,
    RSP_D    = 2'd2
  } rsp_sel_e;

  localparam logic [2:0] STAT_ADR = 3'd3;
endpackage

// File: rtl/dmem_addr_check.sv
// Range check for a word address against the memory depth; any bit above the
// array index makes the access an ADR error.
module dmem_addr_check
  import mem_pkg::*;
(
  input  logic [N-1:0]  addr,
  output logic          in_range,
  output logic [AW-1:0] mem_addr
);
  assign in_range = ~|addr[N-1:AW];
  assign mem_addr = addr[AW-1:0];
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported data memory: D port has priority,
// a streak counter bounds how long a waiting I port can be starved.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int MAX_STREAK = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [N-1:0]  i_addr,
  output logic          i_gnt,
  output logic          i_rsp,
  output logic [N-1:0]  i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [N-1:0]  d_addr,
  input  logic [N-1:0]  d_wdata,
  output logic          d_gnt,
  output logic          d_rsp,
  output logic [N-1:0]  d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata
);
  localparam int SW = $clog2(MAX_STREAK + 1);

  logic [SW-1:0] streak_q, streak_d;
  rsp_sel_e      rsp_sel_q, rsp_sel_d;
  logic          err_q, err_d;
  logic          wr_q, wr_d;
  logic          any_gnt, g_we, in_range;
  logic [N-1:0]  g_addr, rd;

  dmem_addr_check u_chk (
    .addr     (g_addr),
    .in_range (in_range),
    .mem_addr (mem_addr)
  );

  always_comb begin
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    if (!rst) begin
      if (d_req && !(i_req && streak_q == SW'(MAX_STREAK))) d_gnt = 1'b1;
      else if (i_req)                                       i_gnt = 1'b1;
    end
    any_gnt   = d_gnt | i_gnt;
    g_addr    = d_gnt ? d_addr : i_addr;
    g_we      = d_gnt & d_we;
    // Out-of-range accesses never reach the array, so stores there are dropped.
    mem_en    = any_gnt & in_range;
    mem_we    = mem_en & g_we;
    mem_wdata = d_wdata;

    streak_d = streak_q;
    if (!i_req || i_gnt)                                streak_d = '0;
    else if (d_gnt && streak_q != SW'(MAX_STREAK))      streak_d = streak_q + 1'b1;

    rsp_sel_d = d_gnt ? RSP_D : (i_gnt ? RSP_I : RSP_NONE);
    err_d     = any_gnt & ~in_range;
    wr_d      = g_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q  <= '0;
      rsp_sel_q <= RSP_NONE;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      streak_q  <= streak_d;
      rsp_sel_q <= rsp_sel_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
    end
  end

  always_comb begin
    rd      = (!err_q && !wr_q) ? mem_rdata : '0;
    i_rsp   = (rsp_sel_q == RSP_I);
    d_rsp   = (rsp_sel_q == RSP_D);
    i_err   = i_rsp & err_q;
    d_err   = d_rsp & err_q;
    i_rdata = i_rsp ? rd : '0;
    d_rdata = d_rsp ? rd : '0;
  end
endmodule
